pipeline_ctrl: RTL and testbench

Control and hazard unit for the five-stage (F/D/E/M/W) ARM pipeline. It decodes the instruction held in the D register and carries its control bits through E, M and W in its own pipeline registers. It evaluates condition codes against an internal NZCV register and drives the stall, flush and forwarding signals that sequence the datapath's stage registers. Supported instructions: data-processing ADD/SUB/AND/ORR/CMP, LDR/STR, B and BL.

---
 rtl/pipeline_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Control and hazard unit for the five-stage ARM pipeline: D-stage decode, E/M/W control
// registers, condition evaluation against NZCV, and stall/flush/forward generation.
module pipeline_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic [3:0]  ALUFlagsE,
    output logic [1:0]  RegSrcD,
    output logic [1:0]  ImmSrcD,
    output logic        ALUSrcE,
    output logic [2:0]  ALUControlE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        MemWriteM,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic        BrLW,
    output logic        PCSrcW,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        FlushE,
    output logic        BranchTakenE
);

    // D-stage decode
    logic [1:0] op_d;
    logic [3:0] cmd_d;
    logic       reg_write_d, mem_write_d, mem_to_reg_d, brl_d, branch_d;
    logic       flag_write_d, alu_src_d, pc_src_d;
    logic [2:0] alu_ctrl_d;
    logic [3:0] ra1_d, ra2_d, wa3_d;

    assign op_d  = InstrD[27:26];
    assign cmd_d = InstrD[24:21];

    always_comb begin
        reg_write_d  = 1'b0;
        mem_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        brl_d        = 1'b0;
        branch_d     = 1'b0;
        flag_write_d = 1'b0;
        alu_src_d    = 1'b0;
        alu_ctrl_d   = 3'b000;
        RegSrcD      = 2'b00;
        wa3_d        = InstrD[15:12];
        unique case (op_d)
            2'b00: begin
                alu_src_d = InstrD[25];
                case (cmd_d)
                    4'b0100: begin alu_ctrl_d = 3'b000; reg_write_d = 1'b1; flag_write_d = InstrD[20]; end
                    4'b0010: begin alu_ctrl_d = 3'b001; reg_write_d = 1'b1; flag_write_d = InstrD[20]; end
                    4'b0000: begin alu_ctrl_d = 3'b010; reg_write_d = 1'b1; flag_write_d = InstrD[20]; end
                    4'b1100: begin alu_ctrl_d = 3'b011; reg_write_d = 1'b1; flag_write_d = InstrD[20]; end
                    4'b1010: begin alu_ctrl_d = 3'b001; flag_write_d = InstrD[20]; end
                    default: ;
                endcase
            end
            2'b01: begin
                alu_src_d = 1'b1;
                if (InstrD[20]) begin
                    mem_to_reg_d = 1'b1;
                    reg_write_d  = 1'b1;
                end else begin
                    mem_write_d = 1'b1;
                    RegSrcD[1]  = 1'b1;  // store data comes from Rd
                end
            end
            2'b10: begin
                branch_d   = 1'b1;
                alu_src_d  = 1'b1;
                RegSrcD[0] = 1'b1;
                if (InstrD[24]) begin
                    brl_d       = 1'b1;
                    reg_write_d = 1'b1;
                    wa3_d       = 4'd14;
                end
            end
            2'b11: ;
        endcase
    end

    assign ImmSrcD = op_d;
    assign ra1_d   = RegSrcD[0] ? 4'd15 : InstrD[19:16];
    assign ra2_d   = RegSrcD[1] ? InstrD[15:12] : InstrD[3:0];
    // Gated by reset so the combinational stall/flush outputs read 0 while reset is held.
    assign pc_src_d = reset & reg_write_d & (wa3_d == 4'd15) & ~branch_d;

    // E-stage registers
    logic       rw_e_q, mw_e_q, mtr_e_q, brl_e_q, br_e_q, fw_e_q, pcs_e_q, alu_src_e_q;
    logic [2:0] alu_ctrl_e_q;
    logic [3:0] cond_e_q, ra1_e_q, ra2_e_q, wa3_e_q;
    logic [3:0] nzcv_q;

    logic       cond_ex_e, reg_write_e, mem_write_e, pc_src_e, flag_write_e;
    logic       n_f, z_f, c_f, v_f;
    assign {n_f, z_f, c_f, v_f} = nzcv_q;

    always_comb begin
        cond_ex_e = 1'b0;
        unique case (cond_e_q)
            4'b0000: cond_ex_e = z_f;
            4'b0001: cond_ex_e = ~z_f;
            4'b0010: cond_ex_e = c_f;
            4'b0011: cond_ex_e = ~c_f;
            4'b0100: cond_ex_e = n_f;
            4'b0101: cond_ex_e = ~n_f;
            4'b0110: cond_ex_e = v_f;
            4'b0111: cond_ex_e = ~v_f;
            4'b1000: cond_ex_e = c_f & ~z_f;
            4'b1001: cond_ex_e = ~c_f | z_f;
            4'b1010: cond_ex_e = (n_f == v_f);
            4'b1011: cond_ex_e = (n_f != v_f);
            4'b1100: cond_ex_e = ~z_f & (n_f == v_f);
            4'b1101: cond_ex_e = z_f | (n_f != v_f);
            4'b1110: cond_ex_e = 1'b1;
            4'b1111: cond_ex_e = 1'b0;
        endcase
    end

    assign reg_write_e  = rw_e_q & cond_ex_e;
    assign mem_write_e  = mw_e_q & cond_ex_e;
    assign pc_src_e     = pcs_e_q & cond_ex_e;
    assign flag_write_e = fw_e_q & cond_ex_e;
    assign BranchTakenE = br_e_q & cond_ex_e;
    assign ALUSrcE      = alu_src_e_q;
    assign ALUControlE  = alu_ctrl_e_q;

    // M- and W-stage registers
    logic       rw_m_q, mw_m_q, mtr_m_q, brl_m_q, pcs_m_q;
    logic [3:0] wa3_m_q;
    logic       rw_w_q, mtr_w_q, brl_w_q, pcs_w_q;
    logic [3:0] wa3_w_q;

    assign MemWriteM = mw_m_q;
    assign RegWriteW = rw_w_q;
    assign MemtoRegW = mtr_w_q;
    assign BrLW      = brl_w_q;
    assign PCSrcW    = pcs_w_q;

    // Hazards
    logic ldr_stall, pc_wr_pend;
    assign ldr_stall  = mtr_e_q & reg_write_e & ((wa3_e_q == ra1_d) | (wa3_e_q == ra2_d));
    assign pc_wr_pend = pc_src_d | pc_src_e | pcs_m_q;
    assign StallF     = ldr_stall | pc_wr_pend;
    assign StallD     = ldr_stall;
    assign FlushE     = ldr_stall | BranchTakenE;
    assign FlushD     = ((pc_wr_pend | pcs_w_q | BranchTakenE) & ~StallD) | BranchTakenE;

    always_comb begin
        ForwardAE = 2'b00;
        if (rw_m_q && wa3_m_q == ra1_e_q && wa3_m_q != 4'd15) ForwardAE = 2'b10;
        else if (rw_w_q && wa3_w_q == ra1_e_q && wa3_w_q != 4'd15) ForwardAE = 2'b01;
        ForwardBE = 2'b00;
        if (rw_m_q && wa3_m_q == ra2_e_q && wa3_m_q != 4'd15) ForwardBE = 2'b10;
        else if (rw_w_q && wa3_w_q == ra2_e_q && wa3_w_q != 4'd15) ForwardBE = 2'b01;
    end

    // D->E: a flush loads a bubble; a stalled D instruction is re-decoded next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {rw_e_q, mw_e_q, mtr_e_q, brl_e_q, br_e_q, fw_e_q, pcs_e_q, alu_src_e_q} <= '0;
            alu_ctrl_e_q <= '0;
            cond_e_q     <= '0;
            ra1_e_q      <= '0;
            ra2_e_q      <= '0;
            wa3_e_q      <= '0;
        end else if (FlushE) begin
            {rw_e_q, mw_e_q, mtr_e_q, brl_e_q, br_e_q, fw_e_q, pcs_e_q, alu_src_e_q} <= '0;
            alu_ctrl_e_q <= '0;
            cond_e_q     <= '0;
            ra1_e_q      <= '0;
            ra2_e_q      <= '0;
            wa3_e_q      <= '0;
        end else begin
            rw_e_q       <= reg_write_d;
            mw_e_q       <= mem_write_d;
            mtr_e_q      <= mem_to_reg_d;
            brl_e_q      <= brl_d;
            br_e_q       <= branch_d;
            fw_e_q       <= flag_write_d;
            pcs_e_q      <= pc_src_d;
            alu_src_e_q  <= alu_src_d;
            alu_ctrl_e_q <= alu_ctrl_d;
            cond_e_q     <= InstrD[31:28];
            ra1_e_q      <= ra1_d;
            ra2_e_q      <= ra2_d;
            wa3_e_q      <= wa3_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {rw_m_q, mw_m_q, mtr_m_q, brl_m_q, pcs_m_q} <= '0;
            wa3_m_q <= '0;
            {rw_w_q, mtr_w_q, brl_w_q, pcs_w_q} <= '0;
            wa3_w_q <= '0;
            nzcv_q  <= '0;
        end else begin
            rw_m_q  <= reg_write_e;
            mw_m_q  <= mem_write_e;
            mtr_m_q <= mtr_e_q;
            brl_m_q <= brl_e_q;
            pcs_m_q <= pc_src_e;
            wa3_m_q <= wa3_e_q;
            rw_w_q  <= rw_m_q;
            mtr_w_q <= mtr_m_q;
            brl_w_q <= brl_m_q;
            pcs_w_q <= pcs_m_q;
            wa3_w_q <= wa3_m_q;
            if (flag_write_e) nzcv_q <= ALUFlagsE;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed hazard scenarios plus a randomized instruction stream,
// all outputs compared every cycle against an instruction-level reference model.
module tb_pipeline_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] InstrD;
    logic [3:0]  ALUFlagsE;
    logic [1:0]  RegSrcD, ImmSrcD, ForwardAE, ForwardBE;
    logic        ALUSrcE, MemWriteM, RegWriteW, MemtoRegW, BrLW, PCSrcW;
    logic [2:0]  ALUControlE;
    logic        StallF, StallD, FlushD, FlushE, BranchTakenE;

    pipeline_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .InstrD      (InstrD),
        .ALUFlagsE   (ALUFlagsE),
        .RegSrcD     (RegSrcD),
        .ImmSrcD     (ImmSrcD),
        .ALUSrcE     (ALUSrcE),
        .ALUControlE (ALUControlE),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .MemWriteM   (MemWriteM),
        .RegWriteW   (RegWriteW),
        .MemtoRegW   (MemtoRegW),
        .BrLW        (BrLW),
        .PCSrcW      (PCSrcW),
        .StallF      (StallF),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .BranchTakenE(BranchTakenE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] Bubble  = 32'hFC00_0000;
    localparam logic [31:0] SubsR1  = 32'hE051_1001;  // SUBS R1,R1,R1
    localparam logic [31:0] Beq     = 32'h0A00_0002;
    localparam logic [31:0] AddImm  = 32'hE280_8001;  // ADD R8,R0,#1
    localparam logic [31:0] LdrR2   = 32'hE590_2000;  // LDR R2,[R0]
    localparam logic [31:0] AddR3   = 32'hE082_3004;  // ADD R3,R2,R4
    localparam logic [31:0] AddR5   = 32'hE081_5002;  // ADD R5,R1,R2
    localparam logic [31:0] AddR5b  = 32'hE083_5004;  // ADD R5,R3,R4
    localparam logic [31:0] OrrR55  = 32'hE185_6005;  // ORR R6,R5,R5
    localparam logic [31:0] OrrR51  = 32'hE185_6001;  // ORR R6,R5,R1
    localparam logic [31:0] SubR7   = 32'hE045_7001;  // SUB R7,R5,R1
    localparam logic [31:0] AddNeS  = 32'h1091_3002;  // ADDNES R3,R1,R2
    localparam logic [31:0] AddPc   = 32'hE280_F000;  // ADD R15,R0,#0

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: one record per instruction, moved E -> M -> W.
    typedef struct packed {
        logic       rw, mw, mtr, brl, br, fw, pcs, alusrc;
        logic [2:0] alu;
        logic [3:0] cond, ra1, ra2, wa3;
    } instr_t;

    instr_t     pipe [3];
    logic [3:0] m_nzcv;
    instr_t     m_dec;
    logic       m_condex, m_bt, m_ld, m_stallf, m_flushd, m_flushe;
    logic [1:0] m_fa, m_fb;

    function automatic instr_t decode(input logic [31:0] ins);
        instr_t     c;
        logic [3:0] cmd;
        c      = '0;
        cmd    = ins[24:21];
        c.cond = ins[31:28];
        c.wa3  = ins[15:12];
        c.ra1  = ins[19:16];
        c.ra2  = ins[3:0];
        case (ins[27:26])
            2'b00: begin
                c.alusrc = ins[25];
                if (cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010}) begin
                    c.fw  = ins[20];
                    c.rw  = (cmd != 4'b1010);
                    c.alu = (cmd == 4'b0100) ? 3'd0 : (cmd == 4'b0000) ? 3'd2 :
                            (cmd == 4'b1100) ? 3'd3 : 3'd1;
                end
            end
            2'b01: begin
                c.alusrc = 1'b1;
                if (ins[20]) begin c.mtr = 1'b1; c.rw = 1'b1; end
                else begin c.mw = 1'b1; c.ra2 = ins[15:12]; end
            end
            2'b10: begin
                c.br = 1'b1; c.alusrc = 1'b1; c.ra1 = 4'd15;
                if (ins[24]) begin c.brl = 1'b1; c.rw = 1'b1; c.wa3 = 4'd14; end
            end
            default: ;
        endcase
        c.pcs = c.rw && c.wa3 == 4'd15 && !c.br;
        return c;
    endfunction

    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0: return z;            4'h1: return !z;
            4'h2: return c;            4'h3: return !c;
            4'h4: return n;            4'h5: return !n;
            4'h6: return v;            4'h7: return !v;
            4'h8: return c && !z;      4'h9: return !c || z;
            4'hA: return n == v;       4'hB: return n != v;
            4'hC: return !z && n == v; 4'hD: return z || n != v;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [3:0] r);
        if (pipe[1].rw && pipe[1].wa3 == r && r != 4'd15) return 2'b10;
        if (pipe[2].rw && pipe[2].wa3 == r && r != 4'd15) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_comb();
        logic pend;
        m_dec    = decode(InstrD);
        m_condex = cond_holds(pipe[0].cond, m_nzcv);
        m_ld     = pipe[0].mtr && pipe[0].rw && m_condex &&
                   (pipe[0].wa3 == m_dec.ra1 || pipe[0].wa3 == m_dec.ra2);
        m_bt     = pipe[0].br && m_condex;
        pend     = (m_dec.pcs && reset) || (pipe[0].pcs && m_condex) || pipe[1].pcs;
        m_stallf = m_ld || pend;
        m_flushe = m_ld || m_bt;
        m_flushd = ((pend || pipe[2].pcs || m_bt) && !m_ld) || m_bt;
        m_fa     = fwd_sel(pipe[0].ra1);
        m_fb     = fwd_sel(pipe[0].ra2);
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) pipe[k] = '0;
        m_nzcv = 4'h0;
    endtask

    task automatic model_clock();
        instr_t e;
        if (!reset) begin
            model_clear();
        end else begin
            e = pipe[0];
            if (e.fw && m_condex) m_nzcv = ALUFlagsE;
            e.rw  = e.rw && m_condex;
            e.mw  = e.mw && m_condex;
            e.pcs = e.pcs && m_condex;
            pipe[2] = pipe[1];
            pipe[1] = e;
            pipe[0] = m_flushe ? instr_t'('0) : m_dec;
        end
    endtask

    task automatic check_all();
        logic [1:0] exp_regsrc;
        exp_regsrc = {InstrD[27:26] == 2'b01 && !InstrD[20], InstrD[27:26] == 2'b10};
        check_eq("RegSrcD",      32'(RegSrcD),      32'(exp_regsrc));
        check_eq("ImmSrcD",      32'(ImmSrcD),      32'(InstrD[27:26]));
        check_eq("ALUSrcE",      32'(ALUSrcE),      32'(pipe[0].alusrc));
        check_eq("ALUControlE",  32'(ALUControlE),  32'(pipe[0].alu));
        check_eq("ForwardAE",    32'(ForwardAE),    32'(m_fa));
        check_eq("ForwardBE",    32'(ForwardBE),    32'(m_fb));
        check_eq("MemWriteM",    32'(MemWriteM),    32'(pipe[1].mw));
        check_eq("RegWriteW",    32'(RegWriteW),    32'(pipe[2].rw));
        check_eq("MemtoRegW",    32'(MemtoRegW),    32'(pipe[2].mtr));
        check_eq("BrLW",         32'(BrLW),         32'(pipe[2].brl));
        check_eq("PCSrcW",       32'(PCSrcW),       32'(pipe[2].pcs));
        check_eq("StallF",       32'(StallF),       32'(m_stallf));
        check_eq("StallD",       32'(StallD),       32'(m_ld));
        check_eq("FlushD",       32'(FlushD),       32'(m_flushd));
        check_eq("FlushE",       32'(FlushE),       32'(m_flushe));
        check_eq("BranchTakenE", 32'(BranchTakenE), 32'(m_bt));
    endtask

    // One clock: advance model at the edge, drive new inputs, check at the falling edge.
    task automatic step(input logic [31:0] ins, input logic [3:0] fl);
        @(posedge clk);
        model_clock();
        #1;
        InstrD    = ins;
        ALUFlagsE = fl;
        @(negedge clk);
        model_comb();
        check_all();
    endtask

    function automatic logic [3:0] pick_reg();
        int r;
        r = $urandom_range(0, 15);
        if (r < 12) return 4'(r % 4);
        if (r == 12) return 4'd15;
        return 4'(r);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          kind;
        logic [3:0]  cmds [5];
        cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
        w    = $urandom;
        kind = $urandom_range(0, 9);
        w[31:28] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hE;
        w[19:16] = pick_reg();
        w[15:12] = pick_reg();
        w[3:0]   = pick_reg();
        if (kind < 5) begin
            w[27:26] = 2'b00;
            if ($urandom_range(0, 5) != 0) w[24:21] = cmds[$urandom_range(0, 4)];
        end else if (kind < 7) begin
            w[27:26] = 2'b01;
        end else if (kind < 9) begin
            w[27:26] = 2'b10;
        end else begin
            w[27:26] = 2'b11;
        end
        return w;
    endfunction

    int          sf_cnt, pw_cnt;
    logic [31:0] ins;

    initial begin
        reset     = 1'b0;
        InstrD    = AddPc;
        ALUFlagsE = 4'hF;
        model_clear();
        @(negedge clk);
        model_comb();
        check_all();
        check_eq("reset_stallf", 32'(StallF), 32'd0);
        check_eq("reset_flushd", 32'(FlushD), 32'd0);
        InstrD = Bubble;
        #2 reset = 1'b1;
        model_comb();

        // SUBS then BEQ: taken branch flushes D and E, two bubble slots follow.
        step(SubsR1, 4'h0);
        step(Beq,    4'b0100);
        step(AddImm, 4'h0);
        check_eq("beq_taken",  32'(BranchTakenE), 32'd1);
        check_eq("beq_flushd", 32'(FlushD),       32'd1);
        check_eq("beq_flushe", 32'(FlushE),       32'd1);
        step(Bubble, 4'h0);
        check_eq("beq_slot1",  32'({BranchTakenE, ALUSrcE}), 32'd0);
        step(Bubble, 4'h0);
        check_eq("beq_slot2",  32'({BranchTakenE, ALUSrcE}), 32'd0);

        // Load-use: one stall cycle, then W forwarding.
        step(LdrR2, 4'h0);
        step(AddR3, 4'h0);
        check_eq("ldr_stall", 32'({StallF, StallD, FlushE}), 32'b111);
        step(AddR3, 4'h0);
        check_eq("ldr_stall_end", 32'(StallD), 32'd0);
        step(Bubble, 4'h0);
        check_eq("ldr_fwd_a", 32'(ForwardAE), 32'b01);

        // M forwarding, W forwarding, M priority on back-to-back writes.
        step(AddR5, 4'h0);
        step(OrrR55, 4'h0);
        step(Bubble, 4'h0);
        check_eq("fwd_m_a", 32'(ForwardAE), 32'b10);
        check_eq("fwd_m_b", 32'(ForwardBE), 32'b10);
        step(AddR5, 4'h0);
        step(Bubble, 4'h0);
        step(SubR7, 4'h0);
        step(Bubble, 4'h0);
        check_eq("fwd_w_a", 32'(ForwardAE), 32'b01);
        step(AddR5, 4'h0);
        step(AddR5b, 4'h0);
        step(OrrR51, 4'h0);
        step(Bubble, 4'h0);
        check_eq("fwd_prio", 32'(ForwardAE), 32'b10);

        // ADDNES with Z set: no write, no flag update (BEQ still taken).
        step(AddNeS, 4'h0);
        step(Beq, 4'h0);
        step(Bubble, 4'h0);
        check_eq("addne_nzcv_kept", 32'(BranchTakenE), 32'd1);
        step(Bubble, 4'h0);
        check_eq("addne_no_write", 32'(RegWriteW), 32'd0);

        // Write to R15: StallF for 3 cycles, FlushD through the PCSrcW cycle.
        sf_cnt = 0;
        pw_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            step((k == 0) ? AddPc : Bubble, 4'h0);
            sf_cnt += int'(StallF);
            pw_cnt += int'(PCSrcW);
            check_eq("pcw_flushd", 32'(FlushD), (k < 4) ? 32'd1 : 32'd0);
        end
        check_eq("pcw_stallf_cycles", 32'(sf_cnt), 32'd3);
        check_eq("pcw_pcsrcw_once",   32'(pw_cnt), 32'd1);

        // Reset mid-stream with instructions in flight.
        step(SubsR1, 4'hF);
        step(AddR5, 4'hF);
        step(LdrR2, 4'hF);
        step(AddPc, 4'hF);
        #2 reset = 1'b0;
        #1;
        model_clear();
        model_comb();
        check_all();
        check_eq("rst_mid_outs",
                 32'({ALUSrcE, ALUControlE, MemWriteM, RegWriteW, StallF, FlushD, FlushE}),
                 32'd0);
        @(posedge clk);
        model_clock();
        #1 InstrD = Bubble;
        #3 reset = 1'b1;
        @(negedge clk);
        model_comb();
        check_all();
        step(Beq, 4'h0);
        step(Bubble, 4'h0);
        check_eq("rst_nzcv_cleared", 32'(BranchTakenE), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(Bubble, 4'h0);
            check_eq("rst_no_regwrite", 32'(RegWriteW), 32'd0);
        end

        // Random stream; the bench plays datapath by honouring StallD/FlushD.
        for (int i = 0; i < 3000; i++) begin
            if (m_ld) ins = InstrD;
            else if (m_flushd) ins = Bubble;
            else ins = rand_instr();
            step(ins, 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
